// File: rtl/cpu_pkg.sv
// cpu_pkg: constants and types shared by the beat generator and its opcode
// decoder.
//   - OP_NOP..OP_POP : opcode values of cmd[15:11]; OP_LAST is the highest legal one
//   - NUM_OPS        : number of one-hot instruction strobes
//   - B_T0..B_T7     : beat indices of the eight-beat instruction cycle
//   - state_t        : beat generator FSM states. ST_STEP exists only when
//                      BEAT_GEN_STEP_EN is defined.
package cpu_pkg;

   localparam int OPW     = 5;
   localparam int NUM_OPS = 18;

   localparam logic [OPW-1:0] OP_NOP  = 5'd0;
   localparam logic [OPW-1:0] OP_LD   = 5'd1;
   localparam logic [OPW-1:0] OP_LN   = 5'd2;
   localparam logic [OPW-1:0] OP_CP   = 5'd3;
   localparam logic [OPW-1:0] OP_ST   = 5'd4;
   localparam logic [OPW-1:0] OP_SHL  = 5'd5;
   localparam logic [OPW-1:0] OP_ADD  = 5'd6;
   localparam logic [OPW-1:0] OP_SUB  = 5'd7;
   localparam logic [OPW-1:0] OP_JZ   = 5'd8;
   localparam logic [OPW-1:0] OP_JB   = 5'd9;
   localparam logic [OPW-1:0] OP_JMP  = 5'd10;
   localparam logic [OPW-1:0] OP_XOR  = 5'd11;
   localparam logic [OPW-1:0] OP_OR   = 5'd12;
   localparam logic [OPW-1:0] OP_AND  = 5'd13;
   localparam logic [OPW-1:0] OP_SHR  = 5'd14;
   localparam logic [OPW-1:0] OP_NOT  = 5'd15;
   localparam logic [OPW-1:0] OP_PUSH = 5'd16;
   localparam logic [OPW-1:0] OP_POP  = 5'd17;
   localparam logic [OPW-1:0] OP_LAST = 5'd17;

   // Strobe vector holding only _nop: the reset value and the illegal decode.
   localparam logic [NUM_OPS-1:0] NOP_ONEHOT = 18'd1;

   localparam logic [2:0] B_T0 = 3'd0;
   localparam logic [2:0] B_T1 = 3'd1;
   localparam logic [2:0] B_T2 = 3'd2;
   localparam logic [2:0] B_T3 = 3'd3;
   localparam logic [2:0] B_T4 = 3'd4;
   localparam logic [2:0] B_T5 = 3'd5;
   localparam logic [2:0] B_T6 = 3'd6;
   localparam logic [2:0] B_T7 = 3'd7;

`ifdef BEAT_GEN_STEP_EN
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_STEP = 2'd2
   } state_t;
`else
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1
   } state_t;
`endif

endpackage

// File: rtl/op_decode.sv
// op_decode: combinational opcode decoder.
//   opcode  in  OPW     : cmd[15:11]
//   onehot  out NUM_OPS : bit i is high for opcode i. Opcodes above OP_LAST
//                         select bit OP_NOP.
//   illegal out 1       : opcode above OP_LAST
module op_decode
   import cpu_pkg::*;
(
   input  logic [OPW-1:0]     opcode,
   output logic [NUM_OPS-1:0] onehot,
   output logic               illegal
);

   always_comb begin
      onehot  = '0;
      illegal = 1'b0;
      if (opcode > OP_LAST) begin
         onehot[OP_NOP] = 1'b1;
         illegal        = 1'b1;
      end else begin
         for (int i = 0; i < NUM_OPS; i++) begin
            if (opcode == OPW'(i)) onehot[i] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/beat_gen_ir.sv
// beat_gen_ir: eight-beat timing generator, instruction register and
// registered opcode decode for the control unit.
// Optional feature macro: BEAT_GEN_STEP_EN adds the step input and the STEP state.
// Ports:
//   clk, reset      : clock; synchronous active-high reset
//   run, halt, step : execution control. step exists only with BEAT_GEN_STEP_EN.
//   tset            : early restart request from the controller; the next beat is t0
//   iir, eir        : IR load enable; drive the IR address field onto ir_bus
//   bus_in[15:0]    : fetched instruction
//   t0..t7          : one-hot beats, all low in IDLE
//   cmd[15:0]       : instruction register
//   ir_bus[15:0]    : {8'h00, cmd[7:0]} while eir is high, else zero
//   _nop.._pop      : registered one-hot instruction strobes
//   running         : high outside IDLE
//   illegal         : registered; opcode is 18..31
//   dbg_state[1:0]  : current FSM state, for observation
module beat_gen_ir
   import cpu_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        run,
   input  logic        halt,
`ifdef BEAT_GEN_STEP_EN
   input  logic        step,
`endif
   input  logic        tset,
   input  logic        iir,
   input  logic        eir,
   input  logic [15:0] bus_in,
   output logic        t0,
   output logic        t1,
   output logic        t2,
   output logic        t3,
   output logic        t4,
   output logic        t5,
   output logic        t6,
   output logic        t7,
   output logic [15:0] cmd,
   output logic [15:0] ir_bus,
   output logic        _nop,
   output logic        _ld,
   output logic        _ln,
   output logic        _cp,
   output logic        _st,
   output logic        _shl,
   output logic        _add,
   output logic        _sub,
   output logic        _jz,
   output logic        _jb,
   output logic        _jmp,
   output logic        _xor,
   output logic        _or,
   output logic        _and,
   output logic        _shr,
   output logic        _not,
   output logic        _push,
   output logic        _pop,
   output logic        running,
   output logic        illegal,
   output logic [1:0]  dbg_state
);

   state_t             state, state_nx;
   logic [2:0]         beat, beat_nx;
   logic               halt_pend, halt_pend_nx;
   logic [NUM_OPS-1:0] dec_q;
   logic               illegal_q;
   logic [NUM_OPS-1:0] dec_onehot;
   logic               dec_illegal;
   logic               single;
   logic               last_beat;

`ifdef BEAT_GEN_STEP_EN
   assign single = (state == ST_STEP);
`else
   assign single = 1'b0;
`endif

   // The instruction ends at t7 or early on tset.
   assign last_beat = (beat == B_T7) || tset;

   always_comb begin
      state_nx     = state;
      beat_nx      = beat;
      halt_pend_nx = halt_pend;
      if (state == ST_IDLE) begin
         beat_nx      = B_T0;
         halt_pend_nx = 1'b0;
         // run wins over step; halt blocks both.
         if (run && !halt) begin
            state_nx = ST_RUN;
`ifdef BEAT_GEN_STEP_EN
         end else if (step && !halt) begin
            state_nx = ST_STEP;
`endif
         end
      end else begin
         if (halt) halt_pend_nx = 1'b1;
         if (last_beat) begin
            beat_nx = B_T0;
            // A halt raised on the final beat itself still stops this instruction.
            if (halt_pend || halt || single) begin
               state_nx     = ST_IDLE;
               halt_pend_nx = 1'b0;
            end
         end else begin
            beat_nx = beat + 3'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_IDLE;
         beat      <= B_T0;
         halt_pend <= 1'b0;
         cmd       <= 16'h0000;
         dec_q     <= NOP_ONEHOT;
         illegal_q <= 1'b0;
      end else begin
         state     <= state_nx;
         beat      <= beat_nx;
         halt_pend <= halt_pend_nx;
         if (t1 && iir) cmd <= bus_in;
         // Decode the IR loaded at the end of t1 so the strobes are stable from t3.
         if (t2) begin
            dec_q     <= dec_onehot;
            illegal_q <= dec_illegal;
         end
      end
   end

   op_decode u_op_decode (
      .opcode  (cmd[15:11]),
      .onehot  (dec_onehot),
      .illegal (dec_illegal)
   );

   assign running   = (state != ST_IDLE);
   assign dbg_state = state;

   assign t0 = running && (beat == B_T0);
   assign t1 = running && (beat == B_T1);
   assign t2 = running && (beat == B_T2);
   assign t3 = running && (beat == B_T3);
   assign t4 = running && (beat == B_T4);
   assign t5 = running && (beat == B_T5);
   assign t6 = running && (beat == B_T6);
   assign t7 = running && (beat == B_T7);

   assign ir_bus = eir ? {8'h00, cmd[7:0]} : 16'h0000;

   assign _nop    = dec_q[OP_NOP];
   assign _ld     = dec_q[OP_LD];
   assign _ln     = dec_q[OP_LN];
   assign _cp     = dec_q[OP_CP];
   assign _st     = dec_q[OP_ST];
   assign _shl    = dec_q[OP_SHL];
   assign _add    = dec_q[OP_ADD];
   assign _sub    = dec_q[OP_SUB];
   assign _jz     = dec_q[OP_JZ];
   assign _jb     = dec_q[OP_JB];
   assign _jmp    = dec_q[OP_JMP];
   assign _xor    = dec_q[OP_XOR];
   assign _or     = dec_q[OP_OR];
   assign _and    = dec_q[OP_AND];
   assign _shr    = dec_q[OP_SHR];
   assign _not    = dec_q[OP_NOT];
   assign _push   = dec_q[OP_PUSH];
   assign _pop    = dec_q[OP_POP];
   assign illegal = illegal_q;

endmodule

// File: tb/tb_beat_gen_ir.sv
// Directed bench for beat_gen_ir. Inputs change on the falling edge and
// outputs are sampled there, half a cycle away from the active edge.
module tb_beat_gen_ir;

   logic        clk = 1'b0;
   logic        reset, run, halt, tset, iir, eir;
   logic        step;
   logic [15:0] bus_in;
   logic        t0, t1, t2, t3, t4, t5, t6, t7;
   logic [15:0] cmd, ir_bus;
   logic        _nop, _ld, _ln, _cp, _st, _shl, _add, _sub, _jz, _jb;
   logic        _jmp, _xor, _or, _and, _shr, _not, _push, _pop;
   logic        running, illegal;
   logic [1:0]  dbg_state;
   logic [7:0]  beats;
   logic [17:0] strobes;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   beat_gen_ir dut (
      .clk(clk), .reset(reset), .run(run), .halt(halt),
`ifdef BEAT_GEN_STEP_EN
      .step(step),
`endif
      .tset(tset), .iir(iir), .eir(eir), .bus_in(bus_in),
      .t0(t0), .t1(t1), .t2(t2), .t3(t3), .t4(t4), .t5(t5), .t6(t6), .t7(t7),
      .cmd(cmd), .ir_bus(ir_bus),
      ._nop(_nop), ._ld(_ld), ._ln(_ln), ._cp(_cp), ._st(_st), ._shl(_shl),
      ._add(_add), ._sub(_sub), ._jz(_jz), ._jb(_jb), ._jmp(_jmp), ._xor(_xor),
      ._or(_or), ._and(_and), ._shr(_shr), ._not(_not), ._push(_push), ._pop(_pop),
      .running(running), .illegal(illegal), .dbg_state(dbg_state)
   );

   assign beats   = {t7, t6, t5, t4, t3, t2, t1, t0};
   assign strobes = {_pop, _push, _not, _shr, _and, _or, _xor, _jmp, _jb,
                     _jz, _sub, _add, _shl, _st, _cp, _ln, _ld, _nop};

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Called during beat t0 with run already released; walks t1..t7 checking each beat.
   task automatic walk_to_t7(input string tag);
      for (int k = 1; k < 8; k++) begin
         tick();
         check_val(tag, 32'(beats), 32'(8'h01 << k));
      end
   endtask

   initial begin
      reset = 1'b1; run = 1'b0; halt = 1'b0; tset = 1'b0;
      iir = 1'b0; eir = 1'b0; step = 1'b0; bus_in = 16'h0000;
      repeat (2) tick();
      check_val("rst_beats",   32'(beats),   32'h0);
      check_val("rst_running", 32'(running), 32'h0);
      check_val("rst_cmd",     32'(cmd),     32'h0);
      check_val("rst_strobes", 32'(strobes), 32'h1);
      check_val("rst_illegal", 32'(illegal), 32'h0);
      reset = 1'b0;
      tick();
      check_val("idle_beats", 32'(beats), 32'h0);

      // Instruction 1: add, full eight beats, wraps to t0.
      run = 1'b1;
      tick(); run = 1'b0;
      check_val("run_t0",      32'(beats),     32'h01);
      check_val("run_running", 32'(running),   32'h1);
      check_val("run_state",   32'(dbg_state), 32'h1);
      tick(); check_val("i1_t1", 32'(beats), 32'h02);
      bus_in = 16'h3000; iir = 1'b1;
      tick(); iir = 1'b0; bus_in = 16'h0000;
      check_val("i1_t2",  32'(beats), 32'h04);
      check_val("i1_cmd", 32'(cmd),   32'h3000);
      tick();
      check_val("i1_t3",      32'(beats),   32'h08);
      check_val("i1_add",     32'(strobes), 32'h40);
      check_val("i1_illegal", 32'(illegal), 32'h0);
      for (int k = 4; k < 8; k++) begin
         tick(); check_val("i1_beat", 32'(beats), 32'(8'h01 << k));
      end
      tick(); check_val("i1_wrap_t0", 32'(beats), 32'h01);

      // Instruction 2: opcode 20 is illegal; tset at t4 restarts at t0.
      tick(); bus_in = 16'hA000; iir = 1'b1;
      tick(); iir = 1'b0; bus_in = 16'h0000;
      check_val("i2_cmd", 32'(cmd), 32'hA000);
      tick();
      check_val("i2_nop",     32'(strobes), 32'h1);
      check_val("i2_illegal", 32'(illegal), 32'h1);
      tick(); check_val("i2_t4", 32'(beats), 32'h10);
      tset = 1'b1;
      tick(); tset = 1'b0;
      check_val("i2_tset_t0", 32'(beats),   32'h01);
      check_val("i2_tset_run", 32'(running), 32'h1);

      // Instruction 3: ld; halt at t2 then tset at t4 ends in IDLE.
      tick(); bus_in = 16'h0800; iir = 1'b1;
      tick(); iir = 1'b0; bus_in = 16'h0000; halt = 1'b1;
      tick(); halt = 1'b0;
      check_val("i3_ld",      32'(strobes), 32'h2);
      check_val("i3_illegal", 32'(illegal), 32'h0);
      tick(); check_val("i3_t4", 32'(beats), 32'h10);
      tset = 1'b1;
      tick(); tset = 1'b0;
      check_val("i3_halt_beats",   32'(beats),   32'h0);
      check_val("i3_halt_running", 32'(running), 32'h0);

      // tset in IDLE is ignored; run with halt in IDLE stays idle.
      tset = 1'b1;
      tick(); tset = 1'b0;
      check_val("idle_tset_beats", 32'(beats), 32'h0);
      run = 1'b1; halt = 1'b1;
      tick(); run = 1'b0; halt = 1'b0;
      check_val("collide_running", 32'(running), 32'h0);
      check_val("collide_beats",   32'(beats),   32'h0);

      // Instruction 4: pop with address field A5; ir_bus; reset at t5.
      run = 1'b1;
      tick(); run = 1'b0;
      check_val("i4_t0", 32'(beats), 32'h01);
      tick(); bus_in = 16'h88A5; iir = 1'b1;
      tick(); iir = 1'b0; bus_in = 16'h0000;
      check_val("i4_cmd", 32'(cmd), 32'h88A5);
      eir = 1'b1; #1;
      check_val("i4_ir_bus_on", 32'(ir_bus), 32'h00A5);
      eir = 1'b0; #1;
      check_val("i4_ir_bus_off", 32'(ir_bus), 32'h0);
      tick(); check_val("i4_pop", 32'(strobes), 32'h20000);
      tick();
      tick(); check_val("i4_t5", 32'(beats), 32'h20);
      reset = 1'b1;
      tick(); reset = 1'b0;
      check_val("mid_rst_beats",   32'(beats),   32'h0);
      check_val("mid_rst_cmd",     32'(cmd),     32'h0);
      check_val("mid_rst_strobes", 32'(strobes), 32'h1);
      check_val("mid_rst_running", 32'(running), 32'h0);

      // halt raised at t7 stops with no further t0.
      run = 1'b1;
      tick(); run = 1'b0;
      check_val("h7_t0", 32'(beats), 32'h01);
      walk_to_t7("h7_beat");
      halt = 1'b1;
      tick(); halt = 1'b0;
      check_val("h7_beats",   32'(beats),   32'h0);
      check_val("h7_running", 32'(running), 32'h0);

      // Pending halt must not survive into the next run.
      run = 1'b1;
      tick(); run = 1'b0;
      walk_to_t7("rerun_beat");
      tick();
      check_val("rerun_wrap_t0", 32'(beats), 32'h01);
      reset = 1'b1;
      tick(); reset = 1'b0;

`ifdef BEAT_GEN_STEP_EN
      // Single step: exactly t0..t7, then IDLE.
      step = 1'b1;
      tick(); step = 1'b0;
      check_val("step_t0",    32'(beats),     32'h01);
      check_val("step_state", 32'(dbg_state), 32'h2);
      walk_to_t7("step_beat");
      tick();
      check_val("step_end_beats",   32'(beats),   32'h0);
      check_val("step_end_running", 32'(running), 32'h0);
      // run and step together selects RUN.
      run = 1'b1; step = 1'b1;
      tick(); run = 1'b0; step = 1'b0;
      check_val("runstep_state", 32'(dbg_state), 32'h1);
      walk_to_t7("runstep_beat");
      tick();
      check_val("runstep_wrap_t0", 32'(beats), 32'h01);
      reset = 1'b1;
      tick(); reset = 1'b0;
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
